// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;
endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: AND/OR/ADD/SUB/SLT plus carry out of the MSB.
// Opcodes without a single-cycle meaning (MUL, reserved) yield zero.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] y,
  output logic             cout
);
  logic [WIDTH:0] sum;

  // Opcode decode; SUB is a + ~b + 1 so cout=1 means no borrow.
  always_comb begin
    y    = '0;
    cout = 1'b0;
    sum  = '0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(carry_in);
        y    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      OP_SUB: begin
        sum  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        y    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      OP_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: single-cycle logic/arith ops and a WIDTH-step unsigned
// shift-add multiply producing a 2*WIDTH product on {result_hi,result}.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       ALU_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand, acc, acc_step;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 alu_go, mul_go, mul_last;
  logic [WIDTH-1:0]     core_y;
  logic                 core_cout;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op       (ALU_op),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .y        (core_y),
    .cout     (core_cout)
  );

  // One partial product per step; the last step's sum is the final product.
  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (state == S_MUL) && (cnt == CNT_W'(WIDTH-1));
  assign busy     = (state == S_MUL);
  assign zero     = ~|result;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state and accept strobes; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    alu_go    = 1'b0;
    mul_go    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        if (ALU_op == OP_MUL) begin
          mul_go    = 1'b1;
          state_nxt = S_MUL;
        end else begin
          alu_go = 1'b1;
        end
      end
      S_MUL: if (mul_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shift-add datapath: operands latched on accept, so later input changes are harmless.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (mul_go) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (!mul_last) cnt <= cnt + 1'b1;
    end
  end

  // Output registers hold until the next completed op; done is a pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result    <= '0;
      result_hi <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (alu_go) begin
        result    <= core_y;
        result_hi <= '0;
        carry_out <= core_cout;
        done      <= 1'b1;
      end else if (mul_last) begin
        {result_hi, result} <= acc_step;
        carry_out <= 1'b0;
        done      <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: a 32-bit and an 8-bit instance.
module tb_alu_seq_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        start, cin, busy, done, cout, zero;
  logic [2:0]  op;
  logic [31:0] a_i, b_i, res, res_hi;

  // 8-bit instance
  logic        start8, cin8, busy8, done8, cout8, zero8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8, res_hi8;

  int checks = 0;
  int fails  = 0;

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ALU_op(op), .a(a_i), .b(b_i),
    .carry_in(cin), .busy(busy), .done(done), .result(res), .result_hi(res_hi),
    .carry_out(cout), .zero(zero));

  alu_seq_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .ALU_op(op8), .a(a8), .b(b8),
    .carry_in(cin8), .busy(busy8), .done(done8), .result(res8), .result_hi(res_hi8),
    .carry_out(cout8), .zero(zero8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request, return 1ns after the accepting edge with start low.
  task automatic go32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic c);
    @(negedge clk);
    op = o; a_i = x; b_i = y; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic go8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                     input logic c);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Run a 32-bit MUL; n = edges from accept to done, bc = cycles busy was seen high.
  // With inject set, a start(AND) is raised mid-flight and operands are scrambled.
  task automatic mul32(input logic [31:0] x, input logic [31:0] y, input bit inject,
                       output int n, output int bc);
    go32(OP_MUL, x, y, 1'b0);
    n  = 0;
    bc = busy ? 1 : 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (!done && busy) bc++;
      if (inject && n == 5) begin
        start = 1'b1; op = OP_AND; a_i = 32'h0; b_i = 32'h0;
      end
      if (inject && n == 6) start = 1'b0;
    end
    chk("mul_done_seen", done, 1'b1);
    chk("mul_busy_low_at_done", busy, 1'b0);
  endtask

  initial begin
    int n, bc;
    start = 0; op = 0; a_i = 0; b_i = 0; cin = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0; cin8 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", res, 32'h0);
    chk("rst_result_hi", res_hi, 32'h0);
    chk("rst_carry", cout, 1'b0);
    chk("rst_zero", zero, 1'b1);
    @(negedge clk); reset_n = 1'b1;

    // ADD
    go32(OP_ADD, 32'h7FFF0000, 32'h0000FFFF, 1'b0);
    chk("add1_done", done, 1'b1);
    chk("add1_res", res, 32'h7FFFFFFF);
    chk("add1_cout", cout, 1'b0);
    chk("add1_zero", zero, 1'b0);
    chk("add1_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("add1_done_pulse", done, 1'b0);
    chk("add1_hold", res, 32'h7FFFFFFF);
    go32(OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("add2_res", res, 32'hFFFFFFFF);
    chk("add2_cout", cout, 1'b1);

    // SUB (carry_in must be ignored)
    go32(OP_SUB, 32'h00000000, 32'hFFFFFFFF, 1'b1);
    chk("sub1_res", res, 32'h00000001);
    chk("sub1_cout", cout, 1'b0);
    go32(OP_SUB, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("sub2_res", res, 32'h0);
    chk("sub2_zero", zero, 1'b1);
    chk("sub2_cout", cout, 1'b1);

    // SLT
    go32(OP_SLT, 32'hAAAAAAAA, 32'h55555555, 1'b0);
    chk("slt1_res", res, 32'h1);
    chk("slt1_cout", cout, 1'b0);
    go32(OP_SLT, 32'h0, 32'hFFFFFFFF, 1'b0);
    chk("slt2_res", res, 32'h0);
    chk("slt2_zero", zero, 1'b1);

    // Reserved opcode
    go32(OP_ADD, 32'hFFFFFFFF, 32'h1, 1'b0);
    go32(3'b101, 32'h12345678, 32'h1, 1'b1);
    chk("rsv_done", done, 1'b1);
    chk("rsv_res", res, 32'h0);
    chk("rsv_cout", cout, 1'b0);

    // Back-to-back: 4 consecutive accepts, 4 consecutive done pulses
    @(negedge clk);
    start = 1'b1; op = OP_AND; a_i = 32'hFF00FF00; b_i = 32'h0F0F0F0F; cin = 0;
    @(posedge clk); #1;
    chk("b2b0_done", done, 1'b1); chk("b2b0_res", res, 32'h0F000F00);
    @(negedge clk); op = OP_OR; a_i = 32'hF0000000; b_i = 32'h0000000F;
    @(posedge clk); #1;
    chk("b2b1_done", done, 1'b1); chk("b2b1_res", res, 32'hF000000F);
    @(negedge clk); op = OP_ADD; a_i = 32'h1; b_i = 32'h2; cin = 1;
    @(posedge clk); #1;
    chk("b2b2_done", done, 1'b1); chk("b2b2_res", res, 32'h4);
    @(negedge clk); op = OP_SLT; a_i = 32'hFFFFFFFF; b_i = 32'h1; cin = 0;
    @(posedge clk); #1;
    chk("b2b3_done", done, 1'b1); chk("b2b3_res", res, 32'h1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_done", done, 1'b0);

    // MUL with mid-flight start and operand changes
    mul32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, n, bc);
    chk("mul_latency", n, 32);
    chk("mul_busy_cycles", bc, 32);
    chk("mul_lo", res, 32'h00000001);
    chk("mul_hi", res_hi, 32'hFFFFFFFE);
    chk("mul_cout", cout, 1'b0);
    @(posedge clk); #1;
    chk("mul_after_done", done, 1'b0);
    chk("mul_after_busy", busy, 1'b0);
    chk("mul_after_hold", res, 32'h00000001);

    // Single-cycle op after MUL clears result_hi
    go32(OP_OR, 32'h0, 32'h0, 1'b0);
    chk("or_after_mul_hi", res_hi, 32'h0);
    chk("or_after_mul_zero", zero, 1'b1);

    // Reset mid-MUL
    go32(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    go32(OP_ADD, 32'h0, 32'h0, 1'b0); // ignored while busy
    repeat (9) begin @(posedge clk); #1; end
    chk("mid_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_res", res, 32'h0);
    chk("abort_res_hi", res_hi, 32'h0);
    chk("abort_zero", zero, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    n = 0;
    repeat (30) begin @(posedge clk); #1; if (done) n++; end
    chk("abort_no_done", n, 0);
    mul32(32'd3, 32'd5, 1'b0, n, bc);
    chk("mul35_latency", n, 32);
    chk("mul35_lo", res, 32'd15);
    chk("mul35_hi", res_hi, 32'd0);

    // WIDTH=8 instance
    go8(OP_MUL, 8'hFF, 8'h02, 1'b0);
    n = 0;
    while (!done8 && n < 50) begin @(posedge clk); #1; n++; end
    chk("w8_mul_latency", n, 8);
    chk("w8_mul_lo", res8, 8'hFE);
    chk("w8_mul_hi", res_hi8, 8'h01);
    go8(OP_ADD, 8'h80, 8'h80, 1'b0);
    chk("w8_add_done", done8, 1'b1);
    chk("w8_add_res", res8, 8'h00);
    chk("w8_add_cout", cout8, 1'b1);
    chk("w8_add_zero", zero8, 1'b1);
    chk("w8_add_hi", res_hi8, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
